// File: rtl/fetch_stage_pkg.sv
// Shared CPU constants for the fetch stage: reset PC default, NOP word and IF/ID bubble contents.
package fetch_stage_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] INSTR_BYTES      = 32'd4;
  localparam logic [31:0] WORD_ALIGN_MASK  = 32'hFFFF_FFFC;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] instr;
    logic        valid;
  } if_id_t;

  localparam if_id_t BUBBLE = '{pc: 32'h0000_0000, pc_plus4: 32'h0000_0000,
                                instr: NOP_INSTR, valid: 1'b0};

  // Redirect targets are forced onto a word boundary.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & WORD_ALIGN_MASK;
  endfunction

endpackage

// File: rtl/fetch_stage_pc_register.sv
// Program counter register with its next-PC selection (redirect > stall > sequential).
module pc_register
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4
);

  logic [31:0] pc_d;
  logic [31:0] pc_q;

  assign pc       = pc_q;
  assign pc_plus4 = pc_q + INSTR_BYTES;

  always_comb begin
    pc_d = pc_q;
    if (redirect_valid) begin
      pc_d = align_word(redirect_target);
    end else if (!stall) begin
      pc_d = pc_plus4;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, combinational imem address, IF/ID pipeline register
// and a count of instructions accepted into IF/ID.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc_plus4,
  output logic [31:0] if_id_instr,
  output logic        if_id_valid,
  output logic [31:0] fetch_count
);

  logic [31:0] pc;
  logic [31:0] pc_plus4;
  if_id_t      if_id_d;
  if_id_t      if_id_q;
  logic [31:0] fetch_count_d;
  logic [31:0] fetch_count_q;

  pc_register #(
    .RESET_PC(RESET_PC)
  ) u_pc_register (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .pc             (pc),
    .pc_plus4       (pc_plus4)
  );

  assign imem_addr      = pc;
  assign if_id_pc       = if_id_q.pc;
  assign if_id_pc_plus4 = if_id_q.pc_plus4;
  assign if_id_instr    = if_id_q.instr;
  assign if_id_valid    = if_id_q.valid;
  assign fetch_count    = fetch_count_q;

  // A taken redirect squashes the instruction fetched down the wrong path.
  always_comb begin
    if_id_d       = if_id_q;
    fetch_count_d = fetch_count_q;
    if (flush || redirect_valid) begin
      if_id_d = BUBBLE;
    end else if (!stall) begin
      if_id_d       = '{pc: pc, pc_plus4: pc_plus4, instr: imem_instr, valid: 1'b1};
      fetch_count_d = fetch_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      if_id_q       <= BUBBLE;
      fetch_count_q <= 32'd0;
    end else begin
      if_id_q       <= if_id_d;
      fetch_count_q <= fetch_count_d;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized traffic
// compared against a cycle-level behavioural model of the fetch rules.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc_plus4;
  logic [31:0] if_id_instr;
  logic        if_id_valid;
  logic [31:0] fetch_count;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  logic [31:0] m_pc;
  logic [31:0] m_ifpc;
  logic [31:0] m_ifpc4;
  logic [31:0] m_ifinstr;
  logic        m_ifvalid;
  logic [31:0] m_count;

  fetch_stage dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .flush          (flush),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .if_id_pc       (if_id_pc),
    .if_id_pc_plus4 (if_id_pc_plus4),
    .if_id_instr    (if_id_instr),
    .if_id_valid    (if_id_valid),
    .fetch_count    (fetch_count)
  );

  always #5 clk = ~clk;

  // Instruction memory contents: a fixed word at 0, an address-derived pattern elsewhere.
  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    if (addr == 32'h0) return 32'h2004_0003;
    return (addr ^ 32'h5A5A_0000) + 32'h0000_0013;
  endfunction

  assign imem_instr = mem_word(imem_addr);

  function automatic void model_reset();
    m_pc = 32'h0; m_ifpc = 32'h0; m_ifpc4 = 32'h0;
    m_ifinstr = 32'h0; m_ifvalid = 1'b0; m_count = 32'h0;
  endfunction

  // Drive one cycle of inputs, advance past the edge, and advance the model by one edge.
  task automatic tick(input logic s, input logic f, input logic rv, input logic [31:0] rt);
    logic [31:0] old_pc;
    stall = s; flush = f; redirect_valid = rv; redirect_target = rt;
    @(posedge clk);
    #1;
    old_pc = m_pc;
    if (rv)      m_pc = {rt[31:2], 2'b00};
    else if (!s) m_pc = old_pc + 32'd4;
    if (f || rv) begin
      m_ifpc = 32'h0; m_ifpc4 = 32'h0; m_ifinstr = 32'h0; m_ifvalid = 1'b0;
    end else if (!s) begin
      m_ifpc = old_pc; m_ifpc4 = old_pc + 32'd4; m_ifinstr = mem_word(old_pc);
      m_ifvalid = 1'b1; m_count = m_count + 32'd1;
    end
    stall = 1'b0; flush = 1'b0; redirect_valid = 1'b0; redirect_target = 32'h0;
  endtask

  task automatic test_reset();
    reset = 1'b1; stall = 1'b0; flush = 1'b0; redirect_valid = 1'b0; redirect_target = 32'h0;
    #12;
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("[TB] FAIL reset_addr: got %h expected %h", imem_addr, 32'h0); end
    checks++; if (if_id_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", if_id_valid); end
    checks++; if (fetch_count !== 32'h0) begin errors++; $display("[TB] FAIL reset_count: got %h expected 0", fetch_count); end
    reset = 1'b0;
    model_reset();
    tick(1'b0, 1'b0, 1'b0, 32'h0);
    checks++; if (if_id_instr !== 32'h2004_0003) begin errors++; $display("[TB] FAIL first_instr: got %h expected %h", if_id_instr, 32'h2004_0003); end
    checks++; if (if_id_pc !== 32'h0) begin errors++; $display("[TB] FAIL first_pc: got %h expected 0", if_id_pc); end
    checks++; if (if_id_pc_plus4 !== 32'h4) begin errors++; $display("[TB] FAIL first_pc4: got %h expected 4", if_id_pc_plus4); end
    checks++; if (imem_addr !== 32'h4) begin errors++; $display("[TB] FAIL first_addr: got %h expected 4", imem_addr); end
    checks++; if (fetch_count !== 32'h1) begin errors++; $display("[TB] FAIL first_count: got %h expected 1", fetch_count); end
  endtask

  task automatic test_redirect();
    tick(1'b0, 1'b0, 1'b0, 32'h0);
    checks++; if (imem_addr !== 32'h8) begin errors++; $display("[TB] FAIL redir_setup: got %h expected 8", imem_addr); end
    tick(1'b0, 1'b0, 1'b1, 32'h0000_000C);
    checks++; if (imem_addr !== 32'hC) begin errors++; $display("[TB] FAIL redir_pc: got %h expected c", imem_addr); end
    checks++; if (if_id_valid !== 1'b0 || if_id_instr !== 32'h0 || if_id_pc !== 32'h0) begin
      errors++; $display("[TB] FAIL redir_bubble: got valid=%b instr=%h pc=%h expected bubble", if_id_valid, if_id_instr, if_id_pc); end
    tick(1'b0, 1'b0, 1'b0, 32'h0);
    checks++; if (if_id_pc !== 32'hC || if_id_valid !== 1'b1) begin
      errors++; $display("[TB] FAIL redir_load: got pc=%h valid=%b expected pc=c valid=1", if_id_pc, if_id_valid); end
  endtask

  task automatic test_stall();
    logic [31:0] held_count;
    held_count = m_count;
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 1'b0, 1'b0, 32'h0);
      checks++; if (imem_addr !== 32'h10) begin errors++; $display("[TB] FAIL stall_addr%0d: got %h expected 10", i, imem_addr); end
      checks++; if (if_id_pc !== 32'hC || if_id_instr !== mem_word(32'hC) || if_id_valid !== 1'b1) begin
        errors++; $display("[TB] FAIL stall_ifid%0d: got pc=%h instr=%h expected pc=c instr=%h", i, if_id_pc, if_id_instr, mem_word(32'hC)); end
      checks++; if (fetch_count !== held_count) begin errors++; $display("[TB] FAIL stall_count%0d: got %h expected %h", i, fetch_count, held_count); end
    end
    tick(1'b0, 1'b0, 1'b0, 32'h0);
    checks++; if (imem_addr !== 32'h14) begin errors++; $display("[TB] FAIL stall_release: got %h expected 14", imem_addr); end
    checks++; if (if_id_pc !== 32'h10) begin errors++; $display("[TB] FAIL stall_release_pc: got %h expected 10", if_id_pc); end
  endtask

  task automatic test_combo();
    logic [31:0] held_count;
    held_count = m_count;
    tick(1'b1, 1'b1, 1'b1, 32'h0000_0031);
    checks++; if (imem_addr !== 32'h30) begin errors++; $display("[TB] FAIL combo_pc: got %h expected 30", imem_addr); end
    checks++; if (if_id_valid !== 1'b0 || if_id_pc_plus4 !== 32'h0) begin
      errors++; $display("[TB] FAIL combo_bubble: got valid=%b pc4=%h expected 0/0", if_id_valid, if_id_pc_plus4); end
    checks++; if (fetch_count !== held_count) begin errors++; $display("[TB] FAIL combo_count: got %h expected %h", fetch_count, held_count); end
  endtask

  task automatic test_wrap();
    tick(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    checks++; if (imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("[TB] FAIL wrap_redir: got %h expected fffffffc", imem_addr); end
    tick(1'b0, 1'b0, 1'b0, 32'h0);
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("[TB] FAIL wrap_pc0: got %h expected 0", imem_addr); end
    checks++; if (if_id_pc !== 32'hFFFF_FFFC || if_id_pc_plus4 !== 32'h0) begin
      errors++; $display("[TB] FAIL wrap_pc4: got pc=%h pc4=%h expected fffffffc/0", if_id_pc, if_id_pc_plus4); end
    tick(1'b0, 1'b0, 1'b0, 32'h0);
    checks++; if (imem_addr !== 32'h4 || if_id_pc !== 32'h0) begin
      errors++; $display("[TB] FAIL wrap_pc4_next: got addr=%h ifpc=%h expected 4/0", imem_addr, if_id_pc); end
  endtask

  task automatic test_async_reset();
    tick(1'b0, 1'b0, 1'b0, 32'h0);
    stall = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    checks++; if (imem_addr !== 32'h0 || if_id_valid !== 1'b0 || fetch_count !== 32'h0 || if_id_pc !== 32'h0 || if_id_instr !== 32'h0) begin
      errors++; $display("[TB] FAIL async_reset: got addr=%h valid=%b count=%h pc=%h instr=%h expected all 0",
                         imem_addr, if_id_valid, fetch_count, if_id_pc, if_id_instr); end
    reset = 1'b0;
    model_reset();
    tick(1'b0, 1'b0, 1'b0, 32'h0);
    checks++; if (if_id_pc !== 32'h0 || if_id_instr !== 32'h2004_0003 || imem_addr !== 32'h4 || fetch_count !== 32'h1) begin
      errors++; $display("[TB] FAIL post_reset_fetch: got pc=%h instr=%h addr=%h count=%h", if_id_pc, if_id_instr, imem_addr, fetch_count); end
  endtask

  task automatic test_random();
    logic s, f, rv;
    logic [31:0] rt;
    for (int i = 0; i < 300; i++) begin
      s  = ($urandom_range(3) == 0);
      f  = ($urandom_range(7) == 0);
      rv = ($urandom_range(7) == 0);
      rt = $urandom;
      tick(s, f, rv, rt);
      checks++;
      if (imem_addr !== m_pc || if_id_pc !== m_ifpc || if_id_pc_plus4 !== m_ifpc4 ||
          if_id_instr !== m_ifinstr || if_id_valid !== m_ifvalid || fetch_count !== m_count) begin
        errors++;
        $display("[TB] FAIL random%0d: got addr=%h pc=%h pc4=%h instr=%h v=%b cnt=%h expected addr=%h pc=%h pc4=%h instr=%h v=%b cnt=%h",
                 i, imem_addr, if_id_pc, if_id_pc_plus4, if_id_instr, if_id_valid, fetch_count,
                 m_pc, m_ifpc, m_ifpc4, m_ifinstr, m_ifvalid, m_count);
      end
      if (if_id_valid === 1'b1) begin
        checks++;
        if (if_id_pc_plus4 !== if_id_pc + 32'd4) begin
          errors++; $display("[TB] FAIL random_pc4_%0d: got %h expected %h", i, if_id_pc_plus4, if_id_pc + 32'd4);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_redirect();
    test_stall();
    test_combo();
    test_wrap();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC value loaded on reset.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port stall, input, 1, hold PC and IF/ID contents (hazard unit).
REQ-005 SHALL have port flush, input, 1, replace the next IF/ID contents with a bubble.
REQ-006 SHALL have port redirect_valid, input, 1, branch or jump resolved taken this cycle.
REQ-007 SHALL have port redirect_target, input, 32, next-PC value when redirect_valid=1.
REQ-008 SHALL have port imem_addr, output, 32, current PC driven to instruction memory.
REQ-009 SHALL have port imem_instr, input, 32, instruction word returned combinationally for imem_addr.
REQ-010 SHALL have port if_id_pc, output, 32, PC of the instruction held in IF/ID.
REQ-011 SHALL have port if_id_pc_plus4, output, 32, that PC plus 4, for link and branch arithmetic.
REQ-012 SHALL have port if_id_instr, output, 32, instruction word held in IF/ID.
REQ-013 SHALL have port if_id_valid, output, 1, 1 = real instruction, 0 = bubble.
REQ-014 SHALL have port fetch_count, output, 32, count of instructions accepted into IF/ID.

Function
REQ-015 SHALL drive imem_addr combinationally from the PC register, with zero added latency.
REQ-016 SHALL make imem_instr visible on if_id_instr one clock edge after its address is presented.
REQ-017 SHALL update the PC each edge by priority: redirect_valid gives {redirect_target[31:2],2'b00}; else stall holds; else PC+4.
REQ-018 SHALL compute PC+4 modulo 2^32, so 32'hFFFF_FFFC advances to 32'h0000_0000.
REQ-019 SHALL update IF/ID each edge by priority: flush or redirect_valid loads a bubble; else stall holds; else load {PC, PC+4, imem_instr, valid=1}.
REQ-020 SHALL define a bubble as pc=0, pc_plus4=0, instr=32'h0000_0000 (nop), valid=0.
REQ-021 SHALL let redirect and flush override stall in the same cycle.
REQ-022 SHALL increment fetch_count by 1 only on edges where IF/ID loads a valid instruction, wrapping from 2^32-1 to 0.
REQ-023 SHALL keep if_id_pc_plus4 equal to if_id_pc+4 whenever if_id_valid=1.

Reset
REQ-024 SHALL on reset assertion immediately set PC=RESET_PC, IF/ID to a bubble, and fetch_count=0, independent of clk.
REQ-025 SHALL on the first edge after reset deassertion fetch from RESET_PC under the normal priority rules.
REQ-026 SHALL abandon any fetch, stall, or redirect in progress when reset asserts mid-operation, with no residual state.

Structure
REQ-027 SHALL place the RESET_PC default, the NOP word (32'h0000_0000) and the bubble field values in the shared CPU package.
REQ-028 SHALL implement the PC register with its next-PC mux as one sub-module, pc_register; the IF/ID register and counter stay in fetch_stage.

Verification
REQ-029 SHALL cover reset: reset pulse -> imem_addr=0, if_id_valid=0, fetch_count=0; imem returns 32'h20040003 at address 0 -> after first edge if_id_instr=32'h20040003, if_id_pc=0, if_id_pc_plus4=4, imem_addr=4.
REQ-030 SHALL cover a redirect: redirect_valid=1 with target 32'h0000_000C while PC=8 -> next edge PC=0x0C and IF/ID is a bubble; the following edge loads if_id_pc=0x0C.
REQ-031 SHALL cover stall: stall=1 for 3 cycles at PC=0x10 -> imem_addr stays 0x10, IF/ID unchanged, fetch_count unchanged; on release PC=0x14.
REQ-032 SHALL cover stall+flush+redirect together: target 32'h0000_0031 -> PC=0x30 (low bits cleared), IF/ID is a bubble, count unchanged.
REQ-033 SHALL cover wrap-around: redirect to 32'hFFFF_FFFC, then two free edges -> PC=0, then PC=4, with if_id_pc_plus4=0 for the 0xFFFF_FFFC instruction.
REQ-034 SHALL cover asynchronous reset: reset asserted between edges during a stall -> outputs reach their reset values before the next clk edge.
